hazard_stall_ctrl: RTL and testbench

//  Pipeline stall/flush controller; handles the hazards that operand forwarding cannot resolve.

---
 rtl/pipe_pkg.sv | 37 +++
 rtl/hazard_stall_ctrl_if.sv | 38 +++
 rtl/hazard_sat_counter.sv | 23 ++
 rtl/hazard_stall_ctrl.sv | 111 +++++++++++
 tb/tb_hazard_stall_ctrl.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline-control types: hazard FSM state encoding and stage-control words.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    ERR     = 2'd2
  } state_e;

  typedef struct packed {
    logic pcwr;
    logic ifidwr;
    logic ifidflush;
    logic idexwr;
    logic idexbubble;
    logic exmemwr;
    logic memwbbubble;
    logic dmemreq;
  } ctrl_t;

  // Free-running pipeline: every stage register writes, nothing is squashed.
  localparam ctrl_t CTRL_RUN = ctrl_t'(8'b1101_0100);
  // NOP control word: nothing advances, ID/EX and MEM/WB load bubbles, no memory request.
  localparam ctrl_t CTRL_NOP = ctrl_t'(8'b0000_1010);

  function automatic ctrl_t freeze_ctrl(input ctrl_t c);
    ctrl_t r;
    r             = c;
    r.pcwr        = 1'b0;
    r.ifidwr      = 1'b0;
    r.idexwr      = 1'b0;
    r.exmemwr     = 1'b0;
    r.memwbbubble = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side hazard information in, stage enables and memory handshake out.
interface hazard_stall_ctrl_if #(
  parameter int unsigned CNTW = 16
);
  logic [4:0]      ifidrs;
  logic [4:0]      ifidrt;
  logic            ifidusert;
  logic            idexmemrd;
  logic [4:0]      idexrt;
  logic            exbranchtkn;
  logic            exmemmemrd;
  logic            exmemmemwr;
  logic            dmemack;
  logic            dmemreq;
  logic            pcwr;
  logic            ifidwr;
  logic            ifidflush;
  logic            idexwr;
  logic            idexbubble;
  logic            exmemwr;
  logic            memwbbubble;
  logic            memerr;
  logic [CNTW-1:0] stallcnt;

  modport master (
    output ifidrs, ifidrt, ifidusert, idexmemrd, idexrt, exbranchtkn,
           exmemmemrd, exmemmemwr, dmemack,
    input  dmemreq, pcwr, ifidwr, ifidflush, idexwr, idexbubble, exmemwr,
           memwbbubble, memerr, stallcnt
  );

  modport slave (
    input  ifidrs, ifidrt, ifidusert, idexmemrd, idexrt, exbranchtkn,
           exmemmemrd, exmemmemwr, dmemack,
    output dmemreq, pcwr, ifidwr, ifidflush, idexwr, idexbubble, exmemwr,
           memwbbubble, memerr, stallcnt
  );
endinterface

// File: rtl/hazard_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module hazard_sat_counter #(
  parameter int unsigned CNTW = 16
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            inc_i,
  output logic [CNTW-1:0] cnt_o
);

  logic [CNTW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != {CNTW{1'b1}})) begin
      cnt_q <= cnt_q + CNTW'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller: load-use bubble, taken-branch flush, memory-wait freeze with timeout.
module hazard_stall_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MEMTIMEOUT = 16,
  parameter int unsigned CNTW       = 16
) (
  input  logic               clk,
  input  logic               rstn,
  hazard_stall_ctrl_if.slave bus
);

  localparam int unsigned WCW = $clog2(MEMTIMEOUT + 1);

  state_e          state_q, state_d;
  logic [WCW-1:0]  waitcnt_q, waitcnt_d;
  logic            memerr_q, memerr_d;
  logic            memacc;
  logic            luse;
  ctrl_t           ctrl;
  logic [CNTW-1:0] stallcnt;

  assign memacc = bus.exmemmemrd | bus.exmemmemwr;
  assign luse   = bus.idexmemrd && (bus.idexrt != 5'd0) &&
                  ((bus.idexrt == bus.ifidrs) ||
                   (bus.ifidusert && (bus.idexrt == bus.ifidrt)));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= RUN;
      waitcnt_q <= '0;
      memerr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      waitcnt_q <= waitcnt_d;
      memerr_q  <= memerr_d;
    end
  end

  // Priority inside RUN: memory freeze, then branch flush, then load-use bubble.
  always_comb begin
    state_d   = state_q;
    waitcnt_d = waitcnt_q;
    memerr_d  = memerr_q;
    ctrl      = CTRL_RUN;
    unique case (state_q)
      RUN: begin
        ctrl.dmemreq = memacc;
        if (memacc && !bus.dmemack) begin
          ctrl      = freeze_ctrl(ctrl);
          state_d   = MEMWAIT;
          waitcnt_d = WCW'(1);
        end else if (bus.exbranchtkn) begin
          ctrl.ifidflush  = 1'b1;
          ctrl.idexbubble = 1'b1;
        end else if (luse) begin
          ctrl.pcwr       = 1'b0;
          ctrl.ifidwr     = 1'b0;
          ctrl.idexbubble = 1'b1;
        end
      end
      MEMWAIT: begin
        ctrl.dmemreq = memacc;
        if (bus.dmemack) begin
          state_d   = RUN;
          waitcnt_d = '0;
        end else begin
          ctrl      = freeze_ctrl(ctrl);
          waitcnt_d = waitcnt_q + WCW'(1);
          if (waitcnt_d == WCW'(MEMTIMEOUT)) begin
            state_d  = ERR;
            memerr_d = 1'b1;
          end
        end
      end
      ERR: begin
        ctrl         = freeze_ctrl(ctrl);
        ctrl.dmemreq = 1'b0;
      end
      default: begin
        ctrl    = CTRL_NOP;
        state_d = RUN;
      end
    endcase
    if (!rstn) begin
      ctrl = CTRL_NOP;
    end
  end

  // A load-use stall during a freeze is the same lost cycle, so one pcwr=0 increment covers both.
  hazard_sat_counter #(
    .CNTW (CNTW)
  ) u_stall_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .inc_i (rstn && !ctrl.pcwr),
    .cnt_o (stallcnt)
  );

  assign bus.pcwr        = ctrl.pcwr;
  assign bus.ifidwr      = ctrl.ifidwr;
  assign bus.ifidflush   = ctrl.ifidflush;
  assign bus.idexwr      = ctrl.idexwr;
  assign bus.idexbubble  = ctrl.idexbubble;
  assign bus.exmemwr     = ctrl.exmemwr;
  assign bus.memwbbubble = ctrl.memwbbubble;
  assign bus.dmemreq     = ctrl.dmemreq;
  assign bus.memerr      = memerr_q;
  assign bus.stallcnt    = stallcnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl (MEMTIMEOUT=4, CNTW=3).
module tb_hazard_stall_ctrl;

  localparam int unsigned CNTW = 3;

  // Control vector order: pcwr ifidwr ifidflush idexwr idexbubble exmemwr memwbbubble dmemreq
  localparam logic [7:0] C_IDLE   = 8'b1101_0100;
  localparam logic [7:0] C_REQ    = 8'b1101_0101;
  localparam logic [7:0] C_LUSE   = 8'b0001_1100;
  localparam logic [7:0] C_BRANCH = 8'b1111_1100;
  localparam logic [7:0] C_FREEZE = 8'b0000_0011;
  localparam logic [7:0] C_ERR    = 8'b0000_0010;
  localparam logic [7:0] C_RESET  = 8'b0000_1010;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;
  logic [7:0] ctl;

  hazard_stall_ctrl_if #(.CNTW(CNTW)) bus ();

  hazard_stall_ctrl #(
    .MEMTIMEOUT (4),
    .CNTW       (CNTW)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  assign ctl = {bus.pcwr, bus.ifidwr, bus.ifidflush, bus.idexwr,
                bus.idexbubble, bus.exmemwr, bus.memwbbubble, bus.dmemreq};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    bus.ifidrs = 5'd0; bus.ifidrt = 5'd0; bus.ifidusert = 1'b0;
    bus.idexmemrd = 1'b0; bus.idexrt = 5'd0; bus.exbranchtkn = 1'b0;
    bus.exmemmemrd = 1'b0; bus.exmemmemwr = 1'b0; bus.dmemack = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic set_luse();
    bus.idexmemrd = 1'b1; bus.idexrt = 5'd8; bus.ifidrs = 5'd8;
  endtask

  task automatic test_reset();
    idle();
    rstn = 1'b0;
    set_luse();
    bus.exmemmemrd = 1'b1;
    #3;
    checks++;
    if (ctl !== C_RESET) begin
      errors++; $display("FAIL reset_ctl got %b want %b", ctl, C_RESET);
    end
    checks++;
    if ({bus.memerr, bus.stallcnt} !== 4'b0) begin
      errors++; $display("FAIL reset_regs got memerr=%b cnt=%0d want 0/0", bus.memerr, bus.stallcnt);
    end
    do_reset();
    @(negedge clk);
    checks++;
    if (ctl !== C_IDLE) begin
      errors++; $display("FAIL reset_run got %b want %b", ctl, C_IDLE);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    set_luse();
    @(negedge clk);
    checks++;
    if (ctl !== C_LUSE) begin
      errors++; $display("FAIL luse_stall got %b want %b", ctl, C_LUSE);
    end
    step();
    bus.idexmemrd = 1'b0;
    @(negedge clk);
    checks++;
    if (ctl !== C_IDLE || bus.stallcnt !== 3'd1) begin
      errors++; $display("FAIL luse_one_bubble got %b cnt=%0d want %b cnt=1", ctl, bus.stallcnt, C_IDLE);
    end
  endtask

  task automatic test_no_stall();
    do_reset();
    bus.idexmemrd = 1'b1; bus.idexrt = 5'd0; bus.ifidrs = 5'd0;
    @(negedge clk);
    checks++;
    if (ctl !== C_IDLE) begin
      errors++; $display("FAIL luse_r0 got %b want %b", ctl, C_IDLE);
    end
    step();
    bus.idexrt = 5'd8; bus.ifidrs = 5'd3; bus.ifidrt = 5'd8; bus.ifidusert = 1'b0;
    @(negedge clk);
    checks++;
    if (ctl !== C_IDLE) begin
      errors++; $display("FAIL luse_rt_unused got %b want %b", ctl, C_IDLE);
    end
    step();
    bus.ifidusert = 1'b1;
    @(negedge clk);
    checks++;
    if (ctl !== C_LUSE) begin
      errors++; $display("FAIL luse_rt_used got %b want %b", ctl, C_LUSE);
    end
    step();
    idle();
    checks++;
    if (bus.stallcnt !== 3'd1) begin
      errors++; $display("FAIL no_stall_cnt got %0d want 1", bus.stallcnt);
    end
  endtask

  task automatic test_branch();
    do_reset();
    set_luse();
    bus.exbranchtkn = 1'b1;
    @(negedge clk);
    checks++;
    if (ctl !== C_BRANCH) begin
      errors++; $display("FAIL branch_flush got %b want %b", ctl, C_BRANCH);
    end
    step();
    idle();
    checks++;
    if (bus.stallcnt !== 3'd0) begin
      errors++; $display("FAIL branch_cnt got %0d want 0", bus.stallcnt);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    set_luse();
    bus.exmemmemrd = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (ctl !== C_FREEZE) begin
        errors++; $display("FAIL memwait_freeze%0d got %b want %b", i, ctl, C_FREEZE);
      end
      step();
    end
    bus.dmemack = 1'b1;
    @(negedge clk);
    checks++;
    if (ctl !== C_REQ) begin
      errors++; $display("FAIL memwait_release got %b want %b", ctl, C_REQ);
    end
    step();
    checks++;
    if (bus.stallcnt !== 3'd3) begin
      errors++; $display("FAIL memwait_cnt got %0d want 3", bus.stallcnt);
    end
    bus.exmemmemrd = 1'b0; bus.dmemack = 1'b0;
    @(negedge clk);
    checks++;
    if (ctl !== C_LUSE) begin
      errors++; $display("FAIL memwait_luse_after got %b want %b", ctl, C_LUSE);
    end
    step();
    idle();
    bus.exmemmemrd = 1'b1; bus.dmemack = 1'b1;
    @(negedge clk);
    checks++;
    if (ctl !== C_REQ) begin
      errors++; $display("FAIL zero_wait got %b want %b", ctl, C_REQ);
    end
    step();
    idle();
    checks++;
    if (bus.stallcnt !== 3'd4) begin
      errors++; $display("FAIL zero_wait_cnt got %0d want 4", bus.stallcnt);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    bus.exmemmemwr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (ctl !== C_FREEZE || bus.memerr !== 1'b0) begin
        errors++; $display("FAIL timeout_wait%0d got %b memerr=%b want %b memerr=0", i, ctl, bus.memerr, C_FREEZE);
      end
      step();
    end
    @(negedge clk);
    checks++;
    if (ctl !== C_ERR || bus.memerr !== 1'b1 || bus.stallcnt !== 3'd4) begin
      errors++; $display("FAIL timeout_err got %b memerr=%b cnt=%0d want %b memerr=1 cnt=4", ctl, bus.memerr, bus.stallcnt, C_ERR);
    end
    bus.dmemack = 1'b1;
    step();
    @(negedge clk);
    checks++;
    if (ctl !== C_ERR || bus.memerr !== 1'b1) begin
      errors++; $display("FAIL err_sticky got %b memerr=%b want %b memerr=1", ctl, bus.memerr, C_ERR);
    end
    repeat (4) step();
    checks++;
    if (bus.stallcnt !== 3'd7) begin
      errors++; $display("FAIL cnt_saturate got %0d want 7", bus.stallcnt);
    end
    repeat (2) step();
    checks++;
    if (bus.stallcnt !== 3'd7) begin
      errors++; $display("FAIL cnt_hold got %0d want 7", bus.stallcnt);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if (ctl !== C_RESET || bus.memerr !== 1'b0 || bus.stallcnt !== 3'd0) begin
      errors++; $display("FAIL err_reset got %b memerr=%b cnt=%0d want %b memerr=0 cnt=0", ctl, bus.memerr, bus.stallcnt, C_RESET);
    end
    step();
    rstn = 1'b1;
    idle();
    bus.exmemmemrd = 1'b1; bus.dmemack = 1'b1;
    @(negedge clk);
    checks++;
    if (ctl !== C_REQ || bus.memerr !== 1'b0) begin
      errors++; $display("FAIL err_exit_run got %b memerr=%b want %b memerr=0", ctl, bus.memerr, C_REQ);
    end
    step();
    idle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rstn   = 1'b0;
    idle();
    test_reset();
    test_load_use();
    test_no_stall();
    test_branch();
    test_mem_wait();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
